// File: rtl/interrupt_controller_if.sv
// Bundle between the control unit / timer block and the interrupt controller.
// The master side drives flags, enables and control-unit handshakes; the
// slave side (the controller) drives the stage code, vector and pulses.
interface interrupt_controller_if #(
    parameter int NUM_SRC = 4
);
    // Request side: timer flags, enables and the SREG I bit
    logic [NUM_SRC-1:0] irq_flags;
    logic [NUM_SRC-1:0] irq_mask;
    logic               global_ie;

    // Control-unit handshakes
    logic               instr_boundary;
    logic               stage_ack;
    logic               reti_done;

    // Controller outputs
    logic               int_active;
    logic [1:0]         int_stage;
    logic [13:0]        vector_addr;
    logic               pc_overwrite;
    logic               clear_ie;
    logic [NUM_SRC-1:0] flag_clear;
    logic               in_service;

    modport master (
        output irq_flags, irq_mask, global_ie,
        output instr_boundary, stage_ack, reti_done,
        input  int_active, int_stage, vector_addr,
        input  pc_overwrite, clear_ie, flag_clear, in_service
    );

    modport slave (
        input  irq_flags, irq_mask, global_ie,
        input  instr_boundary, stage_ack, reti_done,
        output int_active, int_stage, vector_addr,
        output pc_overwrite, clear_ie, flag_clear, in_service
    );
endinterface

// File: rtl/interrupt_controller.sv
// Prioritised interrupt arbiter and entry sequencer.
// At an instruction boundary in IDLE the lowest-indexed enabled pending flag
// wins; the controller then walks the control unit through push-PCL, push-PCH
// and the one-cycle jump, and tracks the handler until RETI. After each RETI
// one boundary is skipped so the main program always makes progress.
// All outputs are registered and computed from the next state, so they change
// cleanly on the clock edge that enters each stage.
module interrupt_controller #(
    parameter int          NUM_SRC    = 4,
    parameter logic [13:0] VEC_BASE   = 14'h002,
    parameter int          VEC_STRIDE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    interrupt_controller_if.slave bus
);

    localparam int WIDX = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_L,
        S_PUSH_H,
        S_JUMP,
        S_SERVICE
    } state_t;

    // State and latched arbitration result
    state_t               r_state;
    logic                 r_skip;
    logic [WIDX-1:0]      r_winner;
    logic [13:0]          r_vector_addr;

    // Registered outputs
    logic                 r_int_active;
    logic [1:0]           r_int_stage;
    logic                 r_pc_overwrite;
    logic                 r_clear_ie;
    logic [NUM_SRC-1:0]   r_flag_clear;
    logic                 r_in_service;

    // Combinational helpers
    state_t               w_next_state;
    logic [NUM_SRC-1:0]   w_pending;
    logic [WIDX-1:0]      w_winner;
    logic [13:0]          w_vector;
    logic                 w_arbitrate;
    logic                 w_next_int_active;
    logic [1:0]           w_next_int_stage;
    logic                 w_next_pulse;
    logic [NUM_SRC-1:0]   w_next_flag_clear;
    logic                 w_next_in_service;

    assign w_pending = bus.irq_flags & bus.irq_mask;

    // Priority encoder: lowest set index of the pending vector wins
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise a
        // path that leaves it unassigned would infer a latch.
        w_winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_winner = WIDX'(i);
            end
        end
    end

    // Vector for the current candidate; 14-bit arithmetic wraps naturally
    assign w_vector = VEC_BASE + (14'(w_winner) * 14'(VEC_STRIDE));

    // Only a boundary in IDLE with interrupts enabled, something pending and
    // no post-RETI skip outstanding starts an entry sequence
    assign w_arbitrate = (r_state == S_IDLE) && bus.instr_boundary &&
                         bus.global_ie && (|w_pending) && !r_skip;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; handshakes outside their own stage are ignored
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_arbitrate) begin
                    w_next_state = S_PUSH_L;
                end
            end
            S_PUSH_L: begin
                if (bus.stage_ack) begin
                    w_next_state = S_PUSH_H;
                end
            end
            S_PUSH_H: begin
                if (bus.stage_ack) begin
                    w_next_state = S_JUMP;
                end
            end
            S_JUMP: begin
                w_next_state = S_SERVICE;
            end
            S_SERVICE: begin
                if (bus.reti_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, registered below
    always_comb begin
        w_next_int_active = 1'b0;
        w_next_int_stage  = 2'd0;
        w_next_pulse      = 1'b0;
        w_next_flag_clear = '0;
        w_next_in_service = 1'b0;
        case (w_next_state)
            S_PUSH_L: begin
                w_next_int_active = 1'b1;
                w_next_int_stage  = 2'd1;
            end
            S_PUSH_H: begin
                w_next_int_active = 1'b1;
                w_next_int_stage  = 2'd2;
            end
            S_JUMP: begin
                // JUMP is only reached from PUSH_H, so r_winner is the
                // winner latched when the sequence started
                w_next_int_active           = 1'b1;
                w_next_int_stage            = 2'd3;
                w_next_pulse                = 1'b1;
                w_next_flag_clear[r_winner] = 1'b1;
            end
            S_SERVICE: begin
                w_next_in_service = 1'b1;
            end
            default: begin
                w_next_int_active = 1'b0;
            end
        endcase
    end

    // Registered outputs; reset forces them idle so an aborted sequence
    // never emits a stray pulse
    always_ff @(posedge clk) begin
        // NOTE: only control state is reset here; there is no storage array
        // whose contents would need clearing.
        if (reset) begin
            r_int_active   <= 1'b0;
            r_int_stage    <= 2'd0;
            r_pc_overwrite <= 1'b0;
            r_clear_ie     <= 1'b0;
            r_flag_clear   <= '0;
            r_in_service   <= 1'b0;
        end else begin
            r_int_active   <= w_next_int_active;
            r_int_stage    <= w_next_int_stage;
            r_pc_overwrite <= w_next_pulse;
            r_clear_ie     <= w_next_pulse;
            r_flag_clear   <= w_next_flag_clear;
            r_in_service   <= w_next_in_service;
        end
    end

    // Winner and vector are frozen except on the cycle that leaves IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_winner      <= '0;
            r_vector_addr <= VEC_BASE;
        end else if (w_arbitrate) begin
            r_winner      <= w_winner;
            r_vector_addr <= w_vector;
        end
    end

    // Post-RETI skip: set by RETI, consumed by the next boundary in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_skip <= 1'b0;
        end else if ((r_state == S_SERVICE) && bus.reti_done) begin
            r_skip <= 1'b1;
        end else if ((r_state == S_IDLE) && bus.instr_boundary) begin
            r_skip <= 1'b0;
        end
    end

    assign bus.int_active   = r_int_active;
    assign bus.int_stage    = r_int_stage;
    assign bus.vector_addr  = r_vector_addr;
    assign bus.pc_overwrite = r_pc_overwrite;
    assign bus.clear_ie     = r_clear_ie;
    assign bus.flag_clear   = r_flag_clear;
    assign bus.in_service   = r_in_service;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed testbench for interrupt_controller. Inputs are driven 1 ns after
// each rising edge and outputs are sampled at the same point, so each check
// sees the state reached by the preceding edge.
module tb_interrupt_controller;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    interrupt_controller_if #(.NUM_SRC(4)) ifc ();

    interrupt_controller #(
        .NUM_SRC    (4),
        .VEC_BASE   (14'h002),
        .VEC_STRIDE (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.irq_flags      = 4'b0000;
        ifc.irq_mask       = 4'b0000;
        ifc.global_ie      = 1'b0;
        ifc.instr_boundary = 1'b0;
        ifc.stage_ack      = 1'b0;
        ifc.reti_done      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Boundary pulse then two acks; returns sitting in the JUMP cycle
    task automatic enter_to_jump();
        ifc.instr_boundary = 1'b1;
        tick();
        ifc.instr_boundary = 1'b0;
        ifc.stage_ack = 1'b1;
        tick();
        tick();
        ifc.stage_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (ifc.int_stage !== 2'd0 || ifc.int_active !== 1'b0 || ifc.in_service !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_status: stage=%0d active=%b in_service=%b expected 0/0/0",
                     ifc.int_stage, ifc.int_active, ifc.in_service);
        end
        n_checks++;
        if (ifc.pc_overwrite !== 1'b0 || ifc.clear_ie !== 1'b0 || ifc.flag_clear !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_pulses: pc=%b clr_ie=%b fc=%b expected 0/0/0000",
                     ifc.pc_overwrite, ifc.clear_ie, ifc.flag_clear);
        end
        n_checks++;
        if (ifc.vector_addr !== 14'h002) begin
            n_errors++;
            $display("FAIL reset_vector: got %h expected 0002", ifc.vector_addr);
        end
    endtask

    task automatic test_single_source();
        logic [1:0] exp_stage [6];
        int n_pc;
        int n_clr;
        logic [3:0] stray_fc;
        exp_stage = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
        n_pc = 0;
        n_clr = 0;
        stray_fc = 4'b0000;
        do_reset();
        ifc.irq_flags = 4'b0001;
        ifc.irq_mask  = 4'b0001;
        ifc.global_ie = 1'b1;
        ifc.instr_boundary = 1'b1;
        tick();
        ifc.instr_boundary = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (ifc.int_stage !== exp_stage[i] || ifc.int_active !== (exp_stage[i] != 2'd0)) begin
                n_errors++;
                $display("FAIL single_stage[%0d]: stage=%0d active=%b expected %0d/%b",
                         i + 1, ifc.int_stage, ifc.int_active, exp_stage[i], exp_stage[i] != 2'd0);
            end
            if (ifc.pc_overwrite === 1'b1) n_pc++;
            if (ifc.clear_ie === 1'b1) n_clr++;
            if (i == 4) begin
                n_checks++;
                if (ifc.vector_addr !== 14'h002 || ifc.flag_clear !== 4'b0001) begin
                    n_errors++;
                    $display("FAIL single_jump: vec=%h fc=%b expected 0002/0001",
                             ifc.vector_addr, ifc.flag_clear);
                end
            end else begin
                stray_fc = stray_fc | ifc.flag_clear;
            end
            if (i == 5) begin
                n_checks++;
                if (ifc.in_service !== 1'b1) begin
                    n_errors++;
                    $display("FAIL single_in_service: got %b expected 1", ifc.in_service);
                end
            end
            ifc.stage_ack = (i == 1 || i == 3);
            tick();
        end
        ifc.stage_ack = 1'b0;
        n_checks++;
        if (n_pc != 1 || n_clr != 1 || stray_fc !== 4'b0000) begin
            n_errors++;
            $display("FAIL single_pulse_count: pc=%0d clr_ie=%0d stray_fc=%b expected 1/1/0000",
                     n_pc, n_clr, stray_fc);
        end
    endtask

    task automatic test_priority_and_mask();
        do_reset();
        ifc.irq_flags = 4'b1010;
        ifc.irq_mask  = 4'b1111;
        ifc.global_ie = 1'b1;
        enter_to_jump();
        n_checks++;
        if (ifc.int_stage !== 2'd3 || ifc.vector_addr !== 14'h004 || ifc.flag_clear !== 4'b0010) begin
            n_errors++;
            $display("FAIL priority: stage=%0d vec=%h fc=%b expected 3/0004/0010",
                     ifc.int_stage, ifc.vector_addr, ifc.flag_clear);
        end
        do_reset();
        ifc.irq_flags = 4'b0010;
        ifc.irq_mask  = 4'b1000;
        ifc.global_ie = 1'b1;
        enter_to_jump();
        n_checks++;
        if (ifc.int_stage !== 2'd0 || ifc.int_active !== 1'b0 || ifc.pc_overwrite !== 1'b0 ||
            ifc.vector_addr !== 14'h002) begin
            n_errors++;
            $display("FAIL masked: stage=%0d active=%b pc=%b vec=%h expected 0/0/0/0002",
                     ifc.int_stage, ifc.int_active, ifc.pc_overwrite, ifc.vector_addr);
        end
    endtask

    task automatic test_gating();
        do_reset();
        ifc.irq_flags = 4'b0001;
        ifc.irq_mask  = 4'b0001;
        ifc.global_ie = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ifc.instr_boundary = 1'b1;
            tick();
            ifc.instr_boundary = 1'b0;
            n_checks++;
            if (ifc.int_stage !== 2'd0) begin
                n_errors++;
                $display("FAIL gate_blocked[%0d]: stage=%0d expected 0", i, ifc.int_stage);
            end
            tick();
        end
        ifc.global_ie = 1'b1;
        ifc.instr_boundary = 1'b1;
        tick();
        ifc.instr_boundary = 1'b0;
        n_checks++;
        if (ifc.int_stage !== 2'd1 || ifc.int_active !== 1'b1) begin
            n_errors++;
            $display("FAIL gate_enter: stage=%0d active=%b expected 1/1", ifc.int_stage, ifc.int_active);
        end
    endtask

    task automatic test_post_reti_skip();
        do_reset();
        ifc.irq_flags = 4'b0001;
        ifc.irq_mask  = 4'b0001;
        ifc.global_ie = 1'b1;
        enter_to_jump();
        tick();
        ifc.reti_done = 1'b1;
        tick();
        ifc.reti_done = 1'b0;
        n_checks++;
        if (ifc.in_service !== 1'b0 || ifc.int_stage !== 2'd0) begin
            n_errors++;
            $display("FAIL skip_after_reti: in_service=%b stage=%0d expected 0/0",
                     ifc.in_service, ifc.int_stage);
        end
        ifc.instr_boundary = 1'b1;
        tick();
        ifc.instr_boundary = 1'b0;
        n_checks++;
        if (ifc.int_stage !== 2'd0) begin
            n_errors++;
            $display("FAIL skip_first_boundary: stage=%0d expected 0", ifc.int_stage);
        end
        tick();
        ifc.instr_boundary = 1'b1;
        tick();
        ifc.instr_boundary = 1'b0;
        n_checks++;
        if (ifc.int_stage !== 2'd1) begin
            n_errors++;
            $display("FAIL skip_second_boundary: stage=%0d expected 1", ifc.int_stage);
        end
    endtask

    task automatic test_ignored_inputs();
        do_reset();
        ifc.irq_flags = 4'b0001;
        ifc.irq_mask  = 4'b0001;
        ifc.global_ie = 1'b1;
        ifc.stage_ack = 1'b1;
        ifc.reti_done = 1'b1;
        tick();
        ifc.stage_ack = 1'b0;
        ifc.reti_done = 1'b0;
        n_checks++;
        if (ifc.int_stage !== 2'd0) begin
            n_errors++;
            $display("FAIL idle_ack_reti: stage=%0d expected 0", ifc.int_stage);
        end
        ifc.instr_boundary = 1'b1;
        tick();
        n_checks++;
        if (ifc.int_stage !== 2'd1) begin
            n_errors++;
            $display("FAIL no_skip_from_idle_reti: stage=%0d expected 1", ifc.int_stage);
        end
        ifc.irq_flags = 4'b1111;
        tick();
        ifc.instr_boundary = 1'b0;
        n_checks++;
        if (ifc.int_stage !== 2'd1 || ifc.vector_addr !== 14'h002) begin
            n_errors++;
            $display("FAIL no_nesting: stage=%0d vec=%h expected 1/0002", ifc.int_stage, ifc.vector_addr);
        end
        ifc.stage_ack = 1'b1;
        tick();
        tick();
        tick();
        ifc.stage_ack = 1'b0;
        n_checks++;
        if (ifc.in_service !== 1'b1 || ifc.int_stage !== 2'd0) begin
            n_errors++;
            $display("FAIL service_ack_ignored: in_service=%b stage=%0d expected 1/0",
                     ifc.in_service, ifc.int_stage);
        end
        ifc.instr_boundary = 1'b1;
        ifc.reti_done = 1'b1;
        tick();
        ifc.instr_boundary = 1'b0;
        ifc.reti_done = 1'b0;
        n_checks++;
        if (ifc.in_service !== 1'b0 || ifc.int_stage !== 2'd0) begin
            n_errors++;
            $display("FAIL reti_with_boundary: in_service=%b stage=%0d expected 0/0",
                     ifc.in_service, ifc.int_stage);
        end
        ifc.instr_boundary = 1'b1;
        tick();
        ifc.instr_boundary = 1'b0;
        n_checks++;
        if (ifc.int_stage !== 2'd0) begin
            n_errors++;
            $display("FAIL reti_with_boundary_skip: stage=%0d expected 0", ifc.int_stage);
        end
    endtask

    task automatic test_late_flag_and_drop();
        do_reset();
        ifc.irq_flags = 4'b0100;
        ifc.irq_mask  = 4'b1111;
        ifc.global_ie = 1'b1;
        ifc.instr_boundary = 1'b1;
        tick();
        ifc.instr_boundary = 1'b0;
        ifc.irq_flags = 4'b0001;
        ifc.stage_ack = 1'b1;
        tick();
        tick();
        ifc.stage_ack = 1'b0;
        n_checks++;
        if (ifc.int_stage !== 2'd3 || ifc.vector_addr !== 14'h006 || ifc.flag_clear !== 4'b0100) begin
            n_errors++;
            $display("FAIL late_flag: stage=%0d vec=%h fc=%b expected 3/0006/0100",
                     ifc.int_stage, ifc.vector_addr, ifc.flag_clear);
        end
    endtask

    task automatic test_reset_mid_sequence();
        int n_pc;
        n_pc = 0;
        do_reset();
        ifc.irq_flags = 4'b0001;
        ifc.irq_mask  = 4'b0001;
        ifc.global_ie = 1'b1;
        ifc.instr_boundary = 1'b1;
        tick();
        ifc.instr_boundary = 1'b0;
        ifc.stage_ack = 1'b1;
        tick();
        ifc.stage_ack = 1'b0;
        n_checks++;
        if (ifc.int_stage !== 2'd2) begin
            n_errors++;
            $display("FAIL mid_push_h: stage=%0d expected 2", ifc.int_stage);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (ifc.int_stage !== 2'd0 || ifc.int_active !== 1'b0 || ifc.pc_overwrite !== 1'b0 ||
            ifc.clear_ie !== 1'b0 || ifc.flag_clear !== 4'b0000 || ifc.in_service !== 1'b0 ||
            ifc.vector_addr !== 14'h002) begin
            n_errors++;
            $display("FAIL mid_reset: stage=%0d active=%b pc=%b clr=%b fc=%b svc=%b vec=%h expected all idle",
                     ifc.int_stage, ifc.int_active, ifc.pc_overwrite, ifc.clear_ie,
                     ifc.flag_clear, ifc.in_service, ifc.vector_addr);
        end
        ifc.stage_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ifc.pc_overwrite === 1'b1 || ifc.int_stage !== 2'd0) n_pc++;
        end
        ifc.stage_ack = 1'b0;
        n_checks++;
        if (n_pc != 0) begin
            n_errors++;
            $display("FAIL mid_reset_ack: %0d cycles left idle expected 0", n_pc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_source();
        test_priority_and_mask();
        test_gating();
        test_post_reti_skip();
        test_ignored_inputs();
        test_late_flag_and_drop();
        test_reset_mid_sequence();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
